reg_file_mp: RTL and testbench

- Parametrised successor to the single-issue integer register file.
- Configurable data width, depth and read-port count; per-port read enables with output hold (stall support); optional write-to-read bypass; optional hardwired zero register.
- Built-in pending-write scoreboard so issue logic can detect RAW hazards.
- Sits between decode/issue (read, issue) and writeback (write) in the CPU pipeline.

---
 rtl/reg_file_mp.sv | 70 +++++++
 tb/tb_reg_file_mp.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with stall-hold reads, write bypass and pending-write scoreboard
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_reg_write,
    input  logic [ADDR_W-1:0]        i_write_rd,
    input  logic [DATA_W-1:0]        i_write_data,
    input  logic [NUM_RD-1:0]        i_read_en,
    input  logic [NUM_RD*ADDR_W-1:0] i_read_rs,
    output logic [NUM_RD*DATA_W-1:0] o_rs_data,
    output logic [NUM_RD-1:0]        o_rs_pending,
    input  logic                     i_issue_valid,
    input  logic [ADDR_W-1:0]        i_issue_rd,
    output logic                     o_any_pending
);
    logic [DATA_W-1:0]        r_regs [DEPTH];
    logic [DEPTH-1:0]         r_sb;
    logic [DEPTH-1:0]         w_sb_next;
    logic                     w_wr_ok;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;
    logic [NUM_RD-1:0]        w_rd_pend;

    // next scoreboard: writeback clears, issue sets, issue wins on the same index
    always_comb begin
        w_wr_ok = i_reg_write && !(ZERO_REG != 0 && i_write_rd == '0);
        for (int i = 0; i < DEPTH; i++)
            w_sb_next[i] = (r_sb[i] && !(i_reg_write && i_write_rd == ADDR_W'(i)))
                         || (i_issue_valid && i_issue_rd == ADDR_W'(i));
        if (ZERO_REG != 0) w_sb_next[0] = 1'b0;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_rs;
        logic              w_hit;
        logic              w_zero;
        assign w_rs   = i_read_rs[p*ADDR_W +: ADDR_W];
        assign w_hit  = BYPASS != 0 && w_wr_ok && w_rs == i_write_rd;
        assign w_zero = ZERO_REG != 0 && w_rs == '0;
        assign w_rd_data[p*DATA_W +: DATA_W] = w_zero ? '0 : w_hit ? i_write_data : r_regs[w_rs];
        assign w_rd_pend[p] = w_zero ? 1'b0 : w_hit ? w_sb_next[w_rs] : r_sb[w_rs];
    end

    // storage, scoreboard and per-port read registers that hold while their enable is low
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
            r_sb         <= '0;
            o_rs_data    <= '0;
            o_rs_pending <= '0;
        end else begin
            if (w_wr_ok) r_regs[i_write_rd] <= i_write_data;
            r_sb <= w_sb_next;
            for (int p = 0; p < NUM_RD; p++) begin
                if (i_read_en[p]) begin
                    o_rs_data[p*DATA_W +: DATA_W] <= w_rd_data[p*DATA_W +: DATA_W];
                    o_rs_pending[p]               <= w_rd_pend[p];
                end
            end
        end
    end

    assign o_any_pending = |r_sb;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed checks of bypass/non-bypass builds plus a 64x16x3 build against a reference model
module tb_reg_file_mp;
    logic        clk = 1'b0;
    logic        rst, we, iv;
    logic [4:0]  wrd, ird;
    logic [31:0] wd;
    logic [1:0]  ren;
    logic [9:0]  rs;
    logic [63:0] data_a, data_b;
    logic [1:0]  pend_a, pend_b;
    logic        any_a, any_b;
    logic        we_c, iv_c;
    logic [3:0]  wrd_c, ird_c;
    logic [63:0] wd_c;
    logic [2:0]  ren_c;
    logic [11:0] rs_c;
    logic [191:0] data_c;
    logic [2:0]  pend_c;
    logic        any_c;
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.BYPASS(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_reg_write(we), .i_write_rd(wrd), .i_write_data(wd),
        .i_read_en(ren), .i_read_rs(rs), .o_rs_data(data_a), .o_rs_pending(pend_a),
        .i_issue_valid(iv), .i_issue_rd(ird), .o_any_pending(any_a));

    reg_file_mp #(.BYPASS(0)) u_b (
        .i_clk(clk), .i_rst(rst), .i_reg_write(we), .i_write_rd(wrd), .i_write_data(wd),
        .i_read_en(ren), .i_read_rs(rs), .o_rs_data(data_b), .o_rs_pending(pend_b),
        .i_issue_valid(iv), .i_issue_rd(ird), .o_any_pending(any_b));

    reg_file_mp #(.DATA_W(64), .DEPTH(16), .NUM_RD(3)) u_c (
        .i_clk(clk), .i_rst(rst), .i_reg_write(we_c), .i_write_rd(wrd_c), .i_write_data(wd_c),
        .i_read_en(ren_c), .i_read_rs(rs_c), .o_rs_data(data_c), .o_rs_pending(pend_c),
        .i_issue_valid(iv_c), .i_issue_rd(ird_c), .o_any_pending(any_c));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] m [16];
        logic [15:0] msb, nsb;
        logic [63:0] md [3];
        logic [2:0]  mp;
        logic [3:0]  a;
        rst = 1; we = 0; wrd = 0; wd = 0; ren = 0; rs = 0; iv = 0; ird = 0;
        we_c = 0; wrd_c = 0; wd_c = 0; ren_c = 0; rs_c = 0; iv_c = 0; ird_c = 0;
        tick;
        rst = 0;
        chk("rst_data_a", data_a, 64'h0);
        chk("rst_data_b", data_b, 64'h0);
        chk("rst_pend_a", {62'h0, pend_a}, 64'h0);
        chk("rst_any_a", {63'h0, any_a}, 64'h0);
        we = 1; wrd = 5; wd = 32'hDEADBEEF; tick;
        wrd = 6; wd = 32'h77; iv = 1; ird = 6; rst = 1; tick;
        rst = 0; we = 0; iv = 0;
        chk("any_after_rst", {63'h0, any_a}, 64'h0);
        ren = 2'b11; rs = {5'd5, 5'd5}; tick;
        chk("r5_after_rst", data_a, 64'h0);
        chk("r5_pend_after_rst", {62'h0, pend_a}, 64'h0);
        rs = {5'd6, 5'd6}; tick;
        chk("r6_write_in_rst", data_a, 64'h0);
        chk("any_issue_in_rst", {63'h0, any_a}, 64'h0);
        ren = 0; we = 1; wrd = 7; wd = 32'h12345678; tick;
        we = 0; ren = 2'b11; rs = {5'd0, 5'd7}; tick;
        chk("basic_r7_r0_a", data_a, 64'h00000000_12345678);
        chk("basic_r7_r0_b", data_b, 64'h00000000_12345678);
        we = 1; wrd = 0; wd = 32'hFFFFFFFF; ren = 0; tick;
        we = 0; ren = 2'b11; rs = {5'd7, 5'd0}; tick;
        chk("r0_write_dropped", data_a, 64'h12345678_00000000);
        ren = 0; we = 1; wrd = 3; wd = 32'h1; tick;
        wd = 32'hA5A5A5A5; ren = 2'b01; rs = {5'd0, 5'd3}; tick;
        we = 0;
        chk("bypass_on", {32'h0, data_a[31:0]}, 64'hA5A5A5A5);
        chk("bypass_off", {32'h0, data_b[31:0]}, 64'h1);
        tick;
        chk("bypass_on_reread", {32'h0, data_a[31:0]}, 64'hA5A5A5A5);
        chk("bypass_off_reread", {32'h0, data_b[31:0]}, 64'hA5A5A5A5);
        we = 1; wrd = 4; wd = 32'h11; ren = 0; tick;
        we = 0; ren = 2'b01; rs = {5'd0, 5'd4}; tick;
        chk("stall_first", {32'h0, data_a[31:0]}, 64'h11);
        ren = 0; we = 1; wd = 32'h22; tick;
        we = 0;
        chk("stall_hold_a", {32'h0, data_a[31:0]}, 64'h11);
        chk("stall_hold_b", {32'h0, data_b[31:0]}, 64'h11);
        tick;
        chk("stall_hold_idle", {32'h0, data_a[31:0]}, 64'h11);
        ren = 2'b01; tick;
        chk("stall_release", {32'h0, data_a[31:0]}, 64'h22);
        ren = 0; iv = 1; ird = 9; tick;
        iv = 0;
        chk("sb_any_set", {63'h0, any_a}, 64'h1);
        ren = 2'b01; rs = {5'd0, 5'd9}; tick;
        chk("sb_r9_pend", {63'h0, pend_a[0]}, 64'h1);
        ren = 2'b10; rs = {5'd9, 5'd0}; we = 1; wrd = 9; wd = 32'h99; iv = 1; ird = 9; tick;
        we = 0; iv = 0;
        chk("sb_set_wins_a", {63'h0, pend_a[1]}, 64'h1);
        chk("sb_set_wins_b", {63'h0, pend_b[1]}, 64'h1);
        chk("sb_set_wins_any", {63'h0, any_a}, 64'h1);
        ren = 2'b01; rs = {5'd0, 5'd9}; we = 1; wrd = 9; wd = 32'h9A; tick;
        we = 0;
        chk("sb_clr_pend_a", {63'h0, pend_a[0]}, 64'h0);
        chk("sb_clr_pend_b", {63'h0, pend_b[0]}, 64'h1);
        chk("sb_clr_data_a", {32'h0, data_a[31:0]}, 64'h9A);
        chk("sb_clr_data_b", {32'h0, data_b[31:0]}, 64'h99);
        chk("sb_clr_any", {63'h0, any_a}, 64'h0);
        tick;
        chk("sb_clr_reread_b", {31'h0, pend_b[0], data_b[31:0]}, 64'h9A);
        ren = 0; iv = 1; ird = 0; tick;
        iv = 0;
        chk("sb_zero_never", {63'h0, any_a}, 64'h0);
        ren = 2'b11; rs = {5'd7, 5'd7}; tick;
        chk("same_addr_ab", data_a, 64'h12345678_12345678);
        ren = 0;
        rst = 1; tick;
        rst = 0;
        chk("c_rst_data", data_c[63:0], 64'h0);
        chk("c_rst_any", {63'h0, any_c}, 64'h0);
        for (int i = 0; i < 16; i++) m[i] = '0;
        msb = '0; mp = '0;
        for (int p = 0; p < 3; p++) md[p] = '0;
        for (int it = 0; it < 60; it++) begin
            we_c = 1'($urandom_range(0, 1));
            wrd_c = 4'($urandom_range(0, 15));
            wd_c = {$urandom, $urandom};
            ren_c = 3'($urandom_range(0, 7));
            iv_c = ($urandom_range(0, 3) == 0);
            ird_c = 4'($urandom_range(0, 15));
            rs_c = 12'($urandom);
            if (it % 5 == 1) rs_c[3:0] = wrd_c;
            if (it % 4 == 0) begin
                a = 4'($urandom_range(0, 15));
                if (it % 8 == 0) begin a = wrd_c; we_c = 1; end
                rs_c = {a, a, a};
                ren_c = 3'b111;
            end
            nsb = msb;
            if (we_c) nsb[wrd_c] = 1'b0;
            if (iv_c) nsb[ird_c] = 1'b1;
            nsb[0] = 1'b0;
            for (int p = 0; p < 3; p++) begin
                a = rs_c[p*4 +: 4];
                if (ren_c[p]) begin
                    if (a == 0) begin
                        md[p] = '0; mp[p] = 1'b0;
                    end else if (we_c && wrd_c == a) begin
                        md[p] = wd_c; mp[p] = nsb[a];
                    end else begin
                        md[p] = m[a]; mp[p] = msb[a];
                    end
                end
            end
            if (we_c && wrd_c != 0) m[wrd_c] = wd_c;
            msb = nsb;
            tick;
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("c_data%0d_it%0d", p, it), data_c[p*64 +: 64], md[p]);
                chk($sformatf("c_pend%0d_it%0d", p, it), {63'h0, pend_c[p]}, {63'h0, mp[p]});
            end
            chk($sformatf("c_any_it%0d", it), {63'h0, any_c}, {63'h0, |msb});
        end
        we_c = 0; iv_c = 0; ren_c = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
